// File: rtl/uart_tx_scheduler_if.sv
// Echo stream and TX FIFO write port bundle for uart_tx_scheduler.
// master is the scheduler side; slave is the echo source / FIFO side.
interface uart_tx_scheduler_if;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       echo_ready;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;

  modport master (
    input  echo_valid,
    input  echo_data,
    input  fifo_full,
    output echo_ready,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    output echo_valid,
    output echo_data,
    output fifo_full,
    input  echo_ready,
    input  fifo_wr_en,
    input  fifo_wr_data
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO write port between the RX echo stream
// and an atomic "HH:MM:SS\r\n" time-report frame.
module uart_tx_scheduler #(
  parameter bit         ECHO_EN = 1'b1,
  parameter logic [7:0] SEP     = 8'h3A
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_scheduler_if.master    bus,
  input  logic                   report_req,
  input  logic [4:0]             hour,
  input  logic [5:0]             min,
  input  logic [5:0]             sec,
  output logic                   report_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0] state;
  logic       pending;
  logic       last_grant;
  logic [3:0] idx;
  logic [4:0] h_s;
  logic [5:0] m_s;
  logic [5:0] s_s;

  logic       idle;
  logic       grant;
  logic       echo_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] frame_byte;
  logic [7:0] h_bcd;
  logic [7:0] m_bcd;
  logic [7:0] s_bcd;

  // Divide by 10 via repeated compare/subtract; 63 needs at most 6 steps.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign h_bcd = to_bcd({1'b0, h_s});
  assign m_bcd = to_bcd(m_s);
  assign s_bcd = to_bcd(s_s);

  assign idle  = (state == IDLE);
  assign grant = idle & pending &
                 (~bus.echo_valid | ~last_grant | ~ECHO_EN);

  always_comb begin
    frame_byte = 8'h00;
    unique case (idx)
      4'd0:    frame_byte = ascii(h_bcd[7:4]);
      4'd1:    frame_byte = ascii(h_bcd[3:0]);
      4'd2:    frame_byte = SEP;
      4'd3:    frame_byte = ascii(m_bcd[7:4]);
      4'd4:    frame_byte = ascii(m_bcd[3:0]);
      4'd5:    frame_byte = SEP;
      4'd6:    frame_byte = ascii(s_bcd[7:4]);
      4'd7:    frame_byte = ascii(s_bcd[3:0]);
      4'd8:    frame_byte = 8'h0D;
      4'd9:    frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  end

  // Echo yields when a report waits and echo had the last turn.
  always_comb begin
    echo_ready = 1'b0;
    wr_en      = 1'b0;
    wr_data    = bus.echo_data;
    if (!reset) begin
      if (idle) begin
        echo_ready = ECHO_EN & ~bus.fifo_full &
                     ~(pending & ~last_grant);
        wr_en      = bus.echo_valid & echo_ready;
      end else begin
        wr_en   = ~bus.fifo_full;
        wr_data = frame_byte;
      end
    end
  end

  assign bus.echo_ready   = echo_ready;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;
  assign report_busy      = pending | (state == SEND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      last_grant <= 1'b0;
      idx        <= 4'd0;
      h_s        <= 5'd0;
      m_s        <= 6'd0;
      s_s        <= 6'd0;
    end else begin
      pending <= report_req | (pending & ~grant);
      if (idle) begin
        if (wr_en)
          last_grant <= 1'b0;
        if (grant) begin
          h_s        <= hour;
          m_s        <= min;
          s_s        <= sec;
          idx        <= 4'd0;
          last_grant <= 1'b1;
          state      <= SEND;
        end
      end else if (wr_en) begin
        if (idx == 4'd9) begin
          idx   <= 4'd0;
          state <= IDLE;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: report frames, echo,
// contention, FIFO stall, snapshot/merge and mid-frame reset.
module tb_uart_tx_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       report_req;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       report_busy;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(
    .ECHO_EN (1'b1),
    .SEP     (8'h3A)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .report_req  (report_req),
    .hour        (hour),
    .min         (min),
    .sec         (sec),
    .report_busy (report_busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         full_wr = 0;
  logic [7:0] q[$];

  always @(posedge clk) begin
    if (bus.fifo_wr_en) begin
      q.push_back(bus.fifo_wr_data);
      if (bus.fifo_full) full_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input string exp, input int base);
    for (int i = 0; i < exp.len(); i++) begin
      if (base + i < q.size())
        chk(tag, {24'h0, q[base+i]}, {24'h0, exp[i]});
      else
        chk(tag, 32'hFFFF_FFFF, {24'h0, exp[i]});
    end
  endtask

  string f1 = "09:05:42\r\n";
  string f2 = "12:34:56\r\n";
  string f3 = "23:59:63\r\n";
  string f4 = "31:00:09\r\n";
  string f5 = "04:00:00\r\n";

  initial begin
    reset = 1'b1; report_req = 1'b0;
    hour = 5'd0; min = 6'd0; sec = 6'd0;
    bus.echo_valid = 1'b1; bus.echo_data = 8'h55; bus.fifo_full = 1'b0;
    #2;
    chk("rst_ready", {31'h0, bus.echo_ready}, 32'd0);
    chk("rst_wr_en", {31'h0, bus.fifo_wr_en}, 32'd0);
    chk("rst_busy", {31'h0, report_busy}, 32'd0);
    tick; tick;
    reset = 1'b0; bus.echo_valid = 1'b0;
    #1;
    chk("idle_wr_en", {31'h0, bus.fifo_wr_en}, 32'd0);

    // Basic report 09:05:42
    tick; hour = 5'd9; min = 6'd5; sec = 6'd42; report_req = 1'b1; #1;
    chk("t0_busy", {31'h0, report_busy}, 32'd0);
    tick; report_req = 1'b0; #1;
    chk("t1_busy", {31'h0, report_busy}, 32'd1);
    chk("t1_grant_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick; #1;
      chk("rep_wr_en", {31'h0, bus.fifo_wr_en}, 32'd1);
      chk("rep_data", {24'h0, bus.fifo_wr_data}, {24'h0, f1[k]});
      chk("rep_busy", {31'h0, report_busy}, 32'd1);
    end
    tick; #1;
    chk("t12_busy", {31'h0, report_busy}, 32'd0);
    chk("t12_wr_en", {31'h0, bus.fifo_wr_en}, 32'd0);
    chk("rep_count", q.size(), 32'd10);
    chk_q("rep_fifo", f1, 0);
    q.delete();

    // Echo only
    tick; bus.echo_valid = 1'b1; bus.echo_data = 8'h52; #1;
    chk("echo0_ready", {31'h0, bus.echo_ready}, 32'd1);
    chk("echo0_wr", {31'h0, bus.fifo_wr_en}, 32'd1);
    chk("echo0_data", {24'h0, bus.fifo_wr_data}, 32'h52);
    tick; bus.echo_data = 8'h63; #1;
    chk("echo1_ready", {31'h0, bus.echo_ready}, 32'd1);
    chk("echo1_wr", {31'h0, bus.fifo_wr_en}, 32'd1);
    chk("echo1_data", {24'h0, bus.fifo_wr_data}, 32'h63);
    tick; bus.echo_valid = 1'b0; #1;
    chk("echo_off_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    chk("echo_count", q.size(), 32'd2);
    q.delete();

    // Contention with echo_valid held high
    tick; bus.echo_valid = 1'b1; bus.echo_data = 8'h41; report_req = 1'b1; #1;
    chk("ct_echo_a", {31'h0, bus.fifo_wr_en}, 32'd1);
    tick; report_req = 1'b0; #1;
    chk("ct_grant_ready", {31'h0, bus.echo_ready}, 32'd0);
    chk("ct_grant_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick; report_req = (k == 3); #1;
      chk("ct_send_ready", {31'h0, bus.echo_ready}, 32'd0);
      chk("ct_send_data", {24'h0, bus.fifo_wr_data}, {24'h0, f1[k]});
    end
    tick; report_req = 1'b0; #1;
    chk("ct_echo_b_ready", {31'h0, bus.echo_ready}, 32'd1);
    chk("ct_echo_b_data", {24'h0, bus.fifo_wr_data}, 32'h41);
    tick; #1;
    chk("ct_grant2_ready", {31'h0, bus.echo_ready}, 32'd0);
    chk("ct_grant2_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick; #1;
      chk("ct_send2_wr", {31'h0, bus.fifo_wr_en}, 32'd1);
    end
    tick; bus.echo_valid = 1'b0; #1;
    chk("ct_count", q.size(), 32'd22);
    chk("ct_q0", {24'h0, q[0]}, 32'h41);
    chk_q("ct_frame1", f1, 1);
    chk("ct_q11", {24'h0, q[11]}, 32'h41);
    chk_q("ct_frame2", f1, 12);
    q.delete();

    // FIFO stall after idx 4
    tick; hour = 5'd12; min = 6'd34; sec = 6'd56; report_req = 1'b1; #1;
    tick; report_req = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      tick; #1;
      chk("st_pre_data", {24'h0, bus.fifo_wr_data}, {24'h0, f2[k]});
    end
    for (int j = 0; j < 3; j++) begin
      tick; bus.fifo_full = 1'b1; #1;
      chk("st_full_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    end
    tick; bus.fifo_full = 1'b0; #1;
    chk("st_resume_wr", {31'h0, bus.fifo_wr_en}, 32'd1);
    chk("st_resume_data", {24'h0, bus.fifo_wr_data}, 32'h3A);
    for (int k = 6; k < 10; k++) begin
      tick; #1;
    end
    tick; #1;
    chk("st_busy_end", {31'h0, report_busy}, 32'd0);
    chk("st_count", q.size(), 32'd10);
    chk_q("st_fifo", f2, 0);
    q.delete();

    // Snapshot and merged requests
    tick; hour = 5'd23; min = 6'd59; sec = 6'd63; report_req = 1'b1; #1;
    tick; report_req = 1'b0; #1;
    chk("mg_grant_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick;
      if (k == 0) begin hour = 5'd1; min = 6'd2; sec = 6'd3; end
      if (k == 8) begin hour = 5'd31; min = 6'd0; sec = 6'd9; end
      report_req = (k == 2) || (k == 5);
      #1;
      chk("mg_f1_data", {24'h0, bus.fifo_wr_data}, {24'h0, f3[k]});
    end
    tick; #1;
    chk("mg_grant2_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    chk("mg_grant2_busy", {31'h0, report_busy}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick; #1;
      chk("mg_f2_data", {24'h0, bus.fifo_wr_data}, {24'h0, f4[k]});
    end
    repeat (5) tick;
    chk("mg_busy_end", {31'h0, report_busy}, 32'd0);
    chk("mg_count", q.size(), 32'd20);
    chk_q("mg_fifo1", f3, 0);
    chk_q("mg_fifo2", f4, 10);
    q.delete();

    // Reset at idx 6 with a merged request pending
    tick; hour = 5'd4; min = 6'd0; sec = 6'd0; report_req = 1'b1; #1;
    tick; report_req = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      tick; report_req = (k == 1); #1;
    end
    tick; report_req = 1'b0; #1;
    chk("rs_idx6_wr", {31'h0, bus.fifo_wr_en}, 32'd1);
    chk("rs_idx6_data", {24'h0, bus.fifo_wr_data}, {24'h0, f5[6]});
    reset = 1'b1; bus.echo_valid = 1'b1; #1;
    chk("rs_abort_wr", {31'h0, bus.fifo_wr_en}, 32'd0);
    chk("rs_abort_ready", {31'h0, bus.echo_ready}, 32'd0);
    tick; tick;
    bus.echo_valid = 1'b0; reset = 1'b0; #1;
    chk("rs_busy", {31'h0, report_busy}, 32'd0);
    repeat (15) tick;
    chk("rs_busy_late", {31'h0, report_busy}, 32'd0);
    chk("rs_count", q.size(), 32'd6);
    chk_q("rs_fifo", f5.substr(0, 5), 0);
    chk("full_write", full_wr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Arbiter and sequencer for the shared UART TX FIFO write port. It has two requesters. The first is the receive-echo path: a byte-wide valid/ready stream of characters taken from the RX side. The second is a time-report generator, which snapshots the watch's hour/min/sec counters and writes the ASCII frame "HH:MM:SS\r\n" (10 bytes) into the TX FIFO. A report frame is atomic: once it starts, no echo byte is interleaved into it.

## Interface
Parameters:
- ECHO_EN, 1, 1 = echo path enabled; 0 = echo_ready held 0 and echo requests ignored
- SEP, 8'h3A, separator character written between fields (default ':')

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- echo_valid  input  1  echo byte available
- echo_data  input  8  echo byte
- echo_ready  output  1  echo byte accepted this cycle when echo_valid & echo_ready
- report_req  input  1  single-cycle request for one time report
- hour  input  5  current hour, binary 0..31 accepted (0..23 nominal)
- min  input  6  current minute, binary 0..63 accepted
- sec  input  6  current second, binary 0..63 accepted
- report_busy  output  1  report pending or in progress
- fifo_full  input  1  TX FIFO full; no write allowed in a cycle where it is high
- fifo_wr_en  output  1  TX FIFO write strobe, one byte per high cycle
- fifo_wr_data  output  8  byte written when fifo_wr_en = 1

## Operation
- State machine has two states: IDLE and SEND. Registers: pending, last_grant (0 = echo, 1 = report), idx[3:0], and the snapshot registers h_s, m_s, s_s.
- pending is set on report_req. report_req while pending = 1 or state = SEND is merged into the single pending flag, not queued. pending is cleared when a report is granted. If a new report_req arrives in the grant cycle, pending stays set.
- Behaviour in IDLE:
  - echo_ready = ECHO_EN & !fifo_full & !(pending & last_grant == 0).
  - Echo write: when echo_valid & echo_ready, fifo_wr_en = 1 and fifo_wr_data = echo_data in the same cycle (combinational pass-through). last_grant <= 0.
  - Report grant: when pending and (!echo_valid or last_grant == 0 or ECHO_EN = 0), capture h_s/m_s/s_s from the inputs, set idx <= 0, last_grant <= 1, state <= SEND. No write happens in the grant cycle.
  - If both requesters contend, they alternate (round-robin via last_grant). Neither can starve.
- Behaviour in SEND:
  - echo_ready = 0.
  - fifo_wr_en = !fifo_full.
  - fifo_wr_data is selected by idx: 0 → H tens, 1 → H ones, 2 → SEP, 3 → M tens, 4 → M ones, 5 → SEP, 6 → S tens, 7 → S ones, 8 → 8'h0D, 9 → 8'h0A.
  - idx increments only on a cycle with fifo_wr_en = 1. The write at idx 9 returns the state to IDLE.
- Digit conversion:
  - tens = value / 10 and ones = value % 10, computed by a compare/subtract chain (no divider).
  - ASCII = 8'h30 + digit.
  - Full input range is supported. Examples: sec 63 → "63"; hour 31 → "31".
- Frame content comes only from the snapshot. Input changes during SEND do not affect the frame.
- report_busy = pending | (state == SEND).

## Timing
- Reset (asynchronous) sets state IDLE, pending 0, last_grant 0, idx 0, and snapshots 0. While reset is high, fifo_wr_en = 0 and echo_ready = 0 are forced. fifo_wr_data is a don't-care when fifo_wr_en = 0 (it drives echo_data in IDLE).
- Echo latency is 0 cycles: the write occurs in the acceptance cycle.
- Report latency with no stall and no contention:
  - report_req at cycle t.
  - pending = 1 at t+1, grant at t+1.
  - First byte at t+2, last byte at t+11.
  - report_busy falls at t+12.
- fifo_full stalls the frame with no byte lost or duplicated. fifo_wr_en never asserts while fifo_full = 1.
- Reset asserted mid-frame aborts the frame immediately. The partial frame already in the FIFO is not retracted. A pending request is discarded.

## Test plan
- Reset, then report_req with hour=9, min=5, sec=42 and fifo_full=0 → FIFO receives 30 39 3A 30 35 3A 34 32 0D 0A on cycles t+2..t+11, and report_busy is high t+1..t+11.
- Echo only: echo_valid with data 0x52, 0x63 on consecutive cycles → fifo_wr_en high both cycles, data 0x52, 0x63, echo_ready = 1.
- Contention: report pending while echo_valid is continuously high → echo and report alternate. The whole 10-byte frame is written contiguously, and echo_ready = 0 throughout SEND.
- Stall: raise fifo_full for 3 cycles after byte idx 4 → no write while full, and the byte after the stall is idx 5 (':'), with exactly 10 bytes in total.
- Snapshot/merge: hour=23, min=59, sec=63. Change the inputs and pulse report_req twice during SEND → the first frame is "23:59:63\r\n", exactly one further frame follows, and that frame uses the values present at its grant cycle.
- Reset asserted at idx 6 → fifo_wr_en and echo_ready go to 0 immediately. After release, report_busy = 0 and no further frame bytes are written.
